// File: rtl/mips_pkg.sv
// Shared definitions for the MiniMIPS execute-stage divider.
//   state_t           : divider controller states
//   DIV_CYCLES        : trial subtractions per divide (one per clock)
//   DIV_ZERO_QUOTIENT : quotient returned for a zero divisor
//   neg_if()          : conditional two's-complement negate
package mips_pkg;

    localparam int WORD_W  = 32;
    localparam int DIV_CYCLES = 32;
    localparam int COUNT_W = $clog2(DIV_CYCLES);

    localparam logic [WORD_W-1:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;
    localparam logic [WORD_W-1:0] SIGNED_MIN        = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [WORD_W-1:0] neg_if(input logic c, input logic [WORD_W-1:0] v);
        return c ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration, purely combinational.
// Ports:
//   rem_i     : current partial remainder (always < divisor_i)
//   q_msb_i   : next dividend bit, taken from the quotient shift register MSB
//   divisor_i : divisor magnitude
//   rem_o     : partial remainder after the trial subtraction
//   q_bit_o   : quotient bit produced by this iteration
module div_step
    import mips_pkg::*;
(
    input  logic [WORD_W-1:0] rem_i,
    input  logic              q_msb_i,
    input  logic [WORD_W-1:0] divisor_i,
    output logic [WORD_W-1:0] rem_o,
    output logic              q_bit_o
);

    logic [WORD_W:0] partial;
    logic [WORD_W:0] diff;

    assign partial = {rem_i, q_msb_i};
    assign diff    = partial - {1'b0, divisor_i};

    // A borrow out of bit 32 means the divisor did not fit: restore.
    assign q_bit_o = ~diff[WORD_W];
    assign rem_o   = diff[WORD_W] ? partial[WORD_W-1:0] : diff[WORD_W-1:0];

endmodule

// File: rtl/div_32bit_seq.sv
// Iterative 32-bit restoring divider with start/busy/done handshake.
// Optional feature macro: DIV_SIGNED_EN (adds signed_op and signed fix-up).
// Ports:
//   clock, reset          : rising-edge clock, async active-high reset
//   start                 : request, only honoured in IDLE
//   value1, value2        : dividend, divisor (captured on accepted start)
//   signed_op             : 1 = signed divide (DIV_SIGNED_EN builds only)
//   quotient, remainder   : registered results, stable until next accepted start
//   busy                  : high while iterating
//   done                  : one-cycle pulse when results are valid
//   div_zero, overflow    : status for divisor 0 / signed MIN / -1
//
// state | meaning
// IDLE  | waiting for start; results held
// RUN   | one trial subtraction per clock, 32 clocks
// DONE  | results valid, done pulse; start ignored
module div_32bit_seq
    import mips_pkg::*;
#(
    parameter int WIDTH = 32    // only 32 supported
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] value1,
    input  logic [WIDTH-1:0] value2,
`ifdef DIV_SIGNED_EN
    input  logic             signed_op,
`endif
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             overflow
);

    localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(DIV_CYCLES - 1);

    state_t state_q, state_d;

    logic [COUNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   qsr_q, qsr_d;
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               div_zero_q, div_zero_d;
    logic               overflow_q, overflow_d;

    logic               sgn;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH-1:0]   step_rem;
    logic               step_bit;
    logic [WIDTH-1:0]   step_quo;

`ifdef DIV_SIGNED_EN
    assign sgn = signed_op;
`else
    assign sgn = 1'b0;
`endif

    assign mag1 = neg_if(sgn & value1[WIDTH-1], value1);
    assign mag2 = neg_if(sgn & value2[WIDTH-1], value2);

    div_step u_step (
        .rem_i     (rem_q),
        .q_msb_i   (qsr_q[WIDTH-1]),
        .divisor_i (dvsr_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_bit)
    );

    // Dividend bits leave at the top while quotient bits enter at the bottom.
    assign step_quo = {qsr_q[WIDTH-2:0], step_bit};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = (value2 == '0) ? DONE : RUN;
            RUN:     if (count_q == LAST_COUNT) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output registers are loaded on the edge that enters DONE so that
    // results and the done pulse appear together.
    always_comb begin
        count_d     = count_q;
        rem_d       = rem_q;
        qsr_d       = qsr_q;
        dvsr_d      = dvsr_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        ovf_pend_d  = ovf_pend_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        overflow_d  = overflow_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d      = '0;
                    qsr_d      = mag1;
                    dvsr_d     = mag2;
                    count_d    = '0;
                    neg_quo_d  = sgn & (value1[WIDTH-1] ^ value2[WIDTH-1]);
                    neg_rem_d  = sgn & value1[WIDTH-1];
                    ovf_pend_d = sgn & (value1 == SIGNED_MIN) & (value2 == '1);
                    div_zero_d = 1'b0;
                    overflow_d = 1'b0;
                    if (value2 == '0) begin
                        quotient_d  = DIV_ZERO_QUOTIENT;
                        remainder_d = value1;
                        div_zero_d  = 1'b1;
                        done_d      = 1'b1;
                    end else begin
                        busy_d = 1'b1;
                    end
                end
            end
            RUN: begin
                rem_d   = step_rem;
                qsr_d   = step_quo;
                count_d = count_q + 1'b1;
                if (count_q == LAST_COUNT) begin
                    // MIN / -1 falls out naturally as 0x80000000 rem 0.
                    quotient_d  = neg_if(neg_quo_q, step_quo);
                    remainder_d = neg_if(neg_rem_q, step_rem);
                    overflow_d  = ovf_pend_q;
                    done_d      = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q     <= '0;
            rem_q       <= '0;
            qsr_q       <= '0;
            dvsr_q      <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            ovf_pend_q  <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            div_zero_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            count_q     <= count_d;
            rem_q       <= rem_d;
            qsr_q       <= qsr_d;
            dvsr_q      <= dvsr_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            ovf_pend_q  <= ovf_pend_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            div_zero_q  <= div_zero_d;
            overflow_q  <= overflow_d;
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign div_zero  = div_zero_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_div_32bit_seq.sv
module tb_div_32bit_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] value1 = '0;
    logic [31:0] value2 = '0;
`ifdef DIV_SIGNED_EN
    logic        signed_op = 1'b0;
`endif
    logic [31:0] quotient, remainder;
    logic        busy, done, div_zero, overflow;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ov;
        int          acc;
        int          lat;
        int          busy_cycles;
    } exp_t;

    exp_t exp_q[$];
    int   errors   = 0;
    int   checks   = 0;
    int   cyc      = 0;
    int   busy_cnt = 0;

    div_32bit_seq #(.WIDTH(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .value1    (value1),
        .value2    (value2),
`ifdef DIV_SIGNED_EN
        .signed_op (signed_op),
`endif
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain arithmetic on the operands, latency from the handshake rules.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic sg, input int acc);
        exp_t e;
        e.acc = acc;
        e.dz  = 1'b0;
        e.ov  = 1'b0;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = a;
            e.dz = 1'b1;
            e.lat = 1;
            e.busy_cycles = 0;
        end else begin
            e.lat = 33;
            e.busy_cycles = 32;
            if (sg) begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.q = 32'h8000_0000;
                    e.r = 32'd0;
                    e.ov = 1'b1;
                end else begin
                    e.q = $signed(a) / $signed(b);
                    e.r = $signed(a) % $signed(b);
                end
            end else begin
                e.q = a / b;
                e.r = a % b;
            end
        end
        return e;
    endfunction

    // Monitor / scoreboard: pops one expectation per done pulse.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (reset) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1, expected no pending op (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("quotient",    quotient,            e.q);
                    chk("remainder",   remainder,           e.r);
                    chk("div_zero",    {31'd0, div_zero},   {31'd0, e.dz});
                    chk("overflow",    overflow,            {31'd0, e.ov});
                    chk("latency",     cyc - e.acc,         e.lat);
                    chk("busy_cycles", busy_cnt,            e.busy_cycles);
                    chk("busy_at_done", {31'd0, busy},      32'd0);
                end
                busy_cnt = 0;
            end
        end
    end

    // Drive start for one cycle; acc is the cycle in which start is presented.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sg);
        @(negedge clock);
        value1 = a;
        value2 = b;
`ifdef DIV_SIGNED_EN
        signed_op = sg;
`endif
        start = 1'b1;
        exp_q.push_back(model(a, b, sg, cyc));
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL timeout: got %0d pending ops after %0d cycles, expected 0", exp_q.size(), n);
            exp_q.delete();
        end
        @(negedge clock);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_quotient"},  quotient,            32'd0);
        chk({tag, "_remainder"}, remainder,           32'd0);
        chk({tag, "_busy"},      {31'd0, busy},       32'd0);
        chk({tag, "_done"},      {31'd0, done},       32'd0);
        chk({tag, "_div_zero"},  {31'd0, div_zero},   32'd0);
        chk({tag, "_overflow"},  {31'd0, overflow},   32'd0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish before 1000000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        logic [31:0] a, b;
        logic sg;

        repeat (3) @(negedge clock);
        chk_all_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Directed cases
        issue(32'd100, 32'd7, 1'b0);        wait_idle();
        issue(32'hFFFF_FFFF, 32'd1, 1'b0);  wait_idle();
        issue(32'd5, 32'd9, 1'b0);          wait_idle();
        issue(32'd1234, 32'd0, 1'b0);       wait_idle();
`ifdef DIV_SIGNED_EN
        issue(32'hFFFF_FFF9, 32'd2, 1'b1);          wait_idle();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);  wait_idle();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);  wait_idle();
        issue(32'd1234, 32'd0, 1'b1);               wait_idle();
`endif

        // Starts during RUN are ignored
        issue(32'd100, 32'd7, 1'b0);
        repeat (4) @(negedge clock);
        value1 = 32'd50; value2 = 32'd3; start = 1'b1;
        @(negedge clock); start = 1'b0;
        repeat (14) @(negedge clock);
        value1 = 32'd9; value2 = 32'd0; start = 1'b1;
        @(negedge clock); start = 1'b0;
        wait_idle();

        // Start held through DONE is taken in the following IDLE cycle
        issue(32'd1000, 32'd10, 1'b0);
        repeat (30) @(negedge clock);
        value1 = 32'd77; value2 = 32'd5; start = 1'b1;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clock);
            n++;
        end
        @(posedge clock);
        #1;
        exp_q.push_back(model(32'd77, 32'd5, 1'b0, cyc));
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_idle();

        // Reset in the middle of RUN
        issue(32'd100, 32'd7, 1'b0);
        repeat (9) @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("midrun_reset");
        exp_q.delete();
        busy_cnt = 0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        issue(32'd100, 32'd7, 1'b0);
        wait_idle();

        // Randomized operands
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom;
                1:       b = $urandom_range(1, 15);
                2:       b = $urandom >> $urandom_range(0, 31);
                default: b = (i % 8 == 0) ? 32'd0 : $urandom_range(1, 1000);
            endcase
            sg = 1'b0;
`ifdef DIV_SIGNED_EN
            sg = 1'($urandom_range(0, 1));
            if (i % 10 == 3) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
`endif
            issue(a, b, sg);
            wait_idle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
